// File: rtl/parity_serial_tx_pkg.sv
// parity_serial_tx_pkg: shared state encoding, frame constants and parity helper
package parity_serial_tx_pkg;
   localparam int FRAME_BITS = 11;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
   function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction
endpackage

// File: rtl/parity_serial_tx_if.sv
// parity_serial_tx_if: byte handshake in, serial line and status out
//   in_data/in_valid : producer -> transmitter, in_ready back
//   tx_serial        : serial line, idles high
//   busy/parity_bit/done : frame status
interface parity_serial_tx_if
   import parity_serial_tx_pkg::*;
   ();
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              tx_serial;
   logic              busy;
   logic              parity_bit;
   logic              done;
   modport master (output in_data, in_valid,
                   input  in_ready, tx_serial, busy, parity_bit, done);
   modport slave  (input  in_data, in_valid,
                   output in_ready, tx_serial, busy, parity_bit, done);
endinterface

// File: rtl/parity_serial_tx_bit_timer.sv
// parity_serial_tx_bit_timer: counts clk cycles within one serial bit period
//   clk, rst : clock, synchronous active-high reset
//   clear    : hold the count at zero (used while idle)
//   tick     : high on the last cycle of each bit period
module parity_serial_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   logic [15:0] r_cnt;
   assign tick = r_cnt == LAST;
   always_ff @(posedge clk) begin
      if (rst || clear) r_cnt <= '0;
      else r_cnt <= tick ? '0 : r_cnt + 16'd1;
   end
endmodule

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: accepts a byte and sends start, 8 data bits LSB-first, parity, stop
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of parity_serial_tx_if (handshake in, serial/status out)
module parity_serial_tx
   import parity_serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter bit ODD_PARITY   = 1'b0
) (
   input logic               clk,
   input logic               rst,
   parity_serial_tx_if.slave bus
);
   state_t            r_state;
   state_t            w_next;
   logic [DATA_W-1:0] r_shift;
   logic [2:0]        r_idx;
   logic              r_parity;
   logic              w_tick;
   logic              w_accept;
   assign w_accept = bus.in_valid && r_state == IDLE;
   // timer is held clear in IDLE so the first START cycle always starts a fresh bit
   parity_serial_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clear(r_state == IDLE),
      .tick (w_tick)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_idx    <= '0;
         r_parity <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_shift  <= bus.in_data;
            r_parity <= parity_of(bus.in_data, ODD_PARITY);
            r_idx    <= '0;
         end else if (r_state == DATA && w_tick) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 3'd1;
         end
      end
   end
   always_comb begin
      w_next = r_state == IDLE   ? (w_accept ? START : IDLE) :
               !w_tick           ? r_state :
               r_state == START  ? DATA :
               r_state == DATA   ? (r_idx == 3'd7 ? PARITY : DATA) :
               r_state == PARITY ? STOP : IDLE;
   end
   always_comb begin
      bus.in_ready   = r_state == IDLE;
      bus.busy       = r_state != IDLE;
      bus.done       = r_state == STOP && w_tick;
      bus.parity_bit = r_parity;
      bus.tx_serial  = r_state == START  ? 1'b0 :
                       r_state == DATA   ? r_shift[0] :
                       r_state == PARITY ? r_parity : 1'b1;
   end
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: checks an even/4-clk transmitter and an odd/1-clk transmitter
module tb_parity_serial_tx;
   logic clk = 1'b0;
   logic rst4, rst1;
   int   n_tests = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   parity_serial_tx_if if4();
   parity_serial_tx_if if1();
   parity_serial_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) u4 (.clk(clk), .rst(rst4), .bus(if4));
   parity_serial_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b1)) u1 (.clk(clk), .rst(rst1), .bus(if1));
   typedef struct {
      bit         sel;
      logic [7:0] d;
      logic       exp_par;
      bit         chk_frame;
      logic [10:0] exp_frame;
   } vec_t;
   vec_t vecs[8];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic mpar(input logic [7:0] d, input bit odd);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(d[i]);
      return 1'(n % 2) ^ odd;
   endfunction
   function automatic logic [10:0] mframe(input logic [7:0] d, input bit odd);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
      f[9] = mpar(d, odd);
      f[10] = 1'b1;
      return f;
   endfunction
   function automatic logic tx(input bit sel);
      return sel ? if1.tx_serial : if4.tx_serial;
   endfunction
   function automatic logic rdy(input bit sel);
      return sel ? if1.in_ready : if4.in_ready;
   endfunction
   function automatic logic bsy(input bit sel);
      return sel ? if1.busy : if4.busy;
   endfunction
   function automatic logic dn(input bit sel);
      return sel ? if1.done : if4.done;
   endfunction
   function automatic logic par(input bit sel);
      return sel ? if1.parity_bit : if4.parity_bit;
   endfunction
   task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin
         if1.in_valid = v;
         if1.in_data = d;
      end else begin
         if4.in_valid = v;
         if4.in_data = d;
      end
   endtask
   // starts right after the accept edge; samples each bit at its middle cycle
   task automatic capture(input bit sel, input bit pulse, output logic [10:0] got,
                          output int done_at, output int n_done, output bit hs_ok);
      int cpb = sel ? 1 : 4;
      done_at = -1;
      n_done = 0;
      hs_ok = 1'b1;
      got = '0;
      for (int c = 1; c <= 11 * cpb; c++) begin
         @(negedge clk);
         if ((c - 1) % cpb == cpb / 2) got[(c-1)/cpb] = tx(sel);
         if (dn(sel)) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         if (rdy(sel) || !bsy(sel)) hs_ok = 1'b0;
         if (pulse) set_in(sel, c >= 6 && c <= 8, 8'($urandom));
      end
      if (pulse) set_in(sel, 1'b0, 8'($urandom));
   endtask
   task automatic check_frame(input string nm, input bit sel, input logic [7:0] d,
                              input logic [10:0] got, input int done_at, input int n_done, input bit hs_ok);
      int cpb = sel ? 1 : 4;
      chk({nm, " frame"}, 32'(got), 32'(mframe(d, sel)));
      chk({nm, " parity_bit"}, 32'(par(sel)), 32'(mpar(d, sel)));
      chk({nm, " done_cycle"}, 32'(done_at), 32'(11 * cpb));
      chk({nm, " done_count"}, 32'(n_done), 32'd1);
      chk({nm, " ready_low_busy_high"}, 32'(hs_ok), 32'd1);
   endtask
   task automatic frame(input bit sel, input logic [7:0] d, input bit pulse, input string nm,
                        output logic [10:0] got);
      int done_at, n_done;
      bit hs_ok;
      @(negedge clk);
      chk({nm, " ready_idle"}, 32'(rdy(sel)), 32'd1);
      set_in(sel, 1'b1, d);
      @(posedge clk);
      #1 set_in(sel, 1'b0, 8'($urandom));
      capture(sel, pulse, got, done_at, n_done, hs_ok);
      check_frame(nm, sel, d, got, done_at, n_done, hs_ok);
      @(negedge clk);
      chk({nm, " after_done"}, {29'd0, bsy(sel), dn(sel), tx(sel)}, 32'b001);
   endtask
   initial begin
      logic [10:0] got;
      int done_at, n_done, extra;
      bit hs_ok;
      vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 11'h54A};
      vecs[1] = '{1'b0, 8'h01, 1'b1, 1'b0, 11'h000};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 11'h000};
      vecs[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 11'h000};
      vecs[4] = '{1'b0, 8'h7F, 1'b1, 1'b0, 11'h000};
      vecs[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 11'h000};
      vecs[6] = '{1'b1, 8'h03, 1'b1, 1'b0, 11'h000};
      vecs[7] = '{1'b1, 8'h07, 1'b0, 1'b0, 11'h000};
      rst4 = 1'b1;
      rst1 = 1'b1;
      set_in(1'b0, 1'b1, 8'hFF);
      set_in(1'b1, 1'b1, 8'hFF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++)
         chk($sformatf("reset_state dut%0d", s),
             {27'd0, tx(s[0]), rdy(s[0]), bsy(s[0]), dn(s[0]), par(s[0])}, 32'b11000);
      set_in(1'b0, 1'b0, 8'h00);
      set_in(1'b1, 1'b0, 8'h00);
      rst4 = 1'b0;
      rst1 = 1'b0;
      foreach (vecs[i]) begin
         frame(vecs[i].sel, vecs[i].d, 1'b0, $sformatf("vec%0d", i), got);
         chk($sformatf("vec%0d table_parity", i), 32'(par(vecs[i].sel)), 32'(vecs[i].exp_par));
         if (vecs[i].chk_frame) chk($sformatf("vec%0d table_frame", i), 32'(got), 32'(vecs[i].exp_frame));
      end
      // back-to-back with in_valid held high
      @(negedge clk);
      set_in(1'b0, 1'b1, 8'h11);
      @(posedge clk);
      #1 set_in(1'b0, 1'b1, 8'h22);
      capture(1'b0, 1'b0, got, done_at, n_done, hs_ok);
      check_frame("b2b first", 1'b0, 8'h11, got, done_at, n_done, hs_ok);
      @(negedge clk);
      chk("b2b gap ready", {30'd0, rdy(1'b0), bsy(1'b0)}, 32'b10);
      @(posedge clk);
      #1 set_in(1'b0, 1'b0, 8'h00);
      capture(1'b0, 1'b0, got, done_at, n_done, hs_ok);
      check_frame("b2b second", 1'b0, 8'h22, got, done_at, n_done, hs_ok);
      // reset in DATA bit 3 of 8'hC3
      @(negedge clk);
      set_in(1'b0, 1'b1, 8'hC3);
      @(posedge clk);
      #1 set_in(1'b0, 1'b0, 8'h00);
      n_done = 0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (dn(1'b0)) n_done++;
      end
      rst4 = 1'b1;
      @(posedge clk);
      #1 rst4 = 1'b0;
      @(negedge clk);
      chk("midrst state", {28'd0, tx(1'b0), bsy(1'b0), dn(1'b0), rdy(1'b0)}, 32'b1001);
      extra = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (dn(1'b0)) n_done++;
         if (bsy(1'b0) || !tx(1'b0)) extra++;
      end
      chk("midrst no_done", 32'(n_done), 32'd0);
      chk("midrst stays_idle", 32'(extra), 32'd0);
      frame(1'b0, 8'h3C, 1'b0, "post_rst", got);
      // mid-frame in_data changes and in_valid pulses must not disturb or queue
      frame(1'b0, 8'h96, 1'b1, "busy_pulse4", got);
      frame(1'b1, 8'h5A, 1'b1, "busy_pulse1", got);
      extra = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bsy(1'b0) || bsy(1'b1)) extra++;
      end
      chk("busy_pulse no_extra_frame", 32'(extra), 32'd0);
      for (int i = 0; i < 256; i++) frame(1'b0, 8'(i), 1'b0, $sformatf("all%0d", i), got);
      for (int i = 0; i < 40; i++)
         frame(1'b1, 8'($urandom), 1'($urandom), $sformatf("rnd_odd%0d", i), got);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Transmit-side partner to the team's 8-bit parity checker. It accepts a byte over a valid/ready handshake and computes its parity bit. It then shifts out a framed serial word LSB-first: start bit, 8 data bits, parity bit, stop bit. It sits between a byte producer and a serial link whose far end runs the parity checker.

Parameters:
CLKS_PER_BIT, 4, clk cycles each serial bit is held; legal range 1..65535
ODD_PARITY, 0, 0 = even parity (parity bit = ^data); 1 = odd parity (parity bit = ~^data)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  8  byte to send; sampled only on accept
in_valid  input  1  producer has a byte
in_ready  output  1  block can accept; high only in IDLE
tx_serial  output  1  serial line; idles high
busy  output  1  high from the cycle after accept through the last STOP cycle
parity_bit  output  1  parity of the frame in flight; holds the last frame's value in IDLE
done  output  1  one-cycle pulse on the final clk of STOP

Behaviour:
- Reset values, applied on the first rising edge with rst=1:
  - state=IDLE, tx_serial=1, in_ready=1, busy=0, done=0, parity_bit=0.
  - Bit counter and timer are cleared.
- Accept: in_valid && in_ready at a rising edge.
  - Captures in_data into the shift register.
  - Captures parity = (^in_data) ^ ODD_PARITY.
  - Next state is START.
  - in_data is don't-care outside the accept edge; changes mid-frame have no effect.
- Latency: tx_serial goes low on the cycle immediately after the accept edge.
- States, each held exactly CLKS_PER_BIT cycles via the bit timer:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0]. Shift right at the end of each bit. Bit index 0..7; leave after index 7.
  - PARITY: tx=captured parity.
  - STOP: tx=1, then return to IDLE.
- Frame length is 11*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle inclusive.
- Timer: counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary.
  - CLKS_PER_BIT=1 is legal and gives one cycle per bit.
  - Counter width is 16 bits.
- in_ready=0 in every state except IDLE.
  - in_valid while busy is ignored and the byte is not queued.
  - Minimum gap between frames is 1 IDLE cycle: done, then accept at the earliest one cycle later.
- done and busy:
  - done pulses only after a complete STOP.
  - busy drops on the cycle after done.
- Reset mid-frame: on the next edge, return to IDLE with tx_serial=1, busy=0 and no done pulse. A partial frame is abandoned.
- Simultaneous rst and in_valid: rst wins and the byte is not accepted.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - FRAME_BITS=11;
  - DATA_W=8.
- One natural sub-module, bit_timer:
  - Parameterised by CLKS_PER_BIT.
  - Inputs: clk, rst, clear.
  - Output: tick, asserted on the last cycle of each bit period.
- The FSM and shifter stay in parity_serial_tx.

Test Plan:
1. CLKS_PER_BIT=4, even. Send 8'hA5 (4 ones). Required: tx samples mid-bit read 0,1,0,1,0,0,1,0,1,0,1; parity_bit=0; done on cycle 44 after accept.
2. Even parity, send 8'h01 -> parity bit 1. Send 8'h00 -> parity 0. Send 8'hFF -> parity 0. Send 8'h7F -> parity 1. A bench-side 8-bit XOR reference model must match for all 256 values.
3. ODD_PARITY=1, CLKS_PER_BIT=1: send 8'h00 -> parity 1; send 8'h03 -> parity 1; send 8'h07 -> parity 0. Each frame is exactly 11 cycles.
4. Hold in_valid=1 continuously with bytes 8'h11 then 8'h22.
   - Second accept occurs exactly 1 cycle after the first done.
   - in_ready=0 throughout the first frame.
   - The second frame is intact.
5. Assert rst for 1 cycle during DATA bit 3 of 8'hC3.
   - tx_serial=1 and busy=0 on the next edge.
   - No done pulse.
   - A subsequent 8'h3C frame is correct.
6. Change in_data mid-frame and pulse in_valid while busy. The transmitted frame is unchanged and no extra frame is sent.
